// File: rtl/inst_fifo_pkg.sv
// ============================================================================
// Module      : inst_fifo_pkg
// Description : Shared constants, entry layout and helpers for the IF/ID
//               instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fifo_pkg;

    // Reset PC and canonical NOP shown in empty presentation slots
    localparam logic [31:0] PC_RESET  = 32'h1c00_0000;
    localparam logic [31:0] INST_NOP  = 32'h0340_0000;

    // One buffer entry: pc + inst + excp + pred_taken + pred_target
    localparam int WIDTH_IFE     = 104;
    localparam int IFE_PC_LSB    = 0;
    localparam int IFE_INST_LSB  = 32;
    localparam int IFE_EXCP_LSB  = 64;
    localparam int IFE_PT_BIT    = 71;
    localparam int IFE_TGT_LSB   = 72;

    // Legal fetch-packet valid masks
    localparam logic [1:0] MASK_ONE = 2'b01;
    localparam logic [1:0] MASK_TWO = 2'b11;

    // Packed so that pc occupies bits [31:0] and target bits [103:72]
    typedef struct packed {
        logic [31:0] target;
        logic        pred_taken;
        logic [6:0]  excp;
        logic [31:0] inst;
        logic [31:0] pc;
    } ife_t;

    // Value presented on a slot that has no valid entry behind it
    function automatic ife_t ife_bubble();
        ife_t b;
        b.target     = 32'd0;
        b.pred_taken = 1'b0;
        b.excp       = 7'd0;
        b.inst       = INST_NOP;
        b.pc         = PC_RESET;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fifo_ram.sv
// ============================================================================
// Module      : inst_fifo_ram
// Description : DEPTH x WIDTH_IFE storage with two write ports and two
//               asynchronous read ports. Contents are not reset; validity is
//               tracked by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  ife_t          wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  ife_t          wdata1,
    input  logic [AW-1:0] raddr0,
    output ife_t          rdata0,
    input  logic [AW-1:0] raddr1,
    output ife_t          rdata1
);

    ife_t mem_q [DEPTH];

    // Store up to two entries per cycle; the controller never aims both ports at one address
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_q[waddr0] <= wdata0;
        end
        if (we1) begin
            mem_q[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

`default_nettype wire

// File: rtl/inst_fifo.sv
// ============================================================================
// Module      : inst_fifo
// Description : Two-in / two-out instruction buffer between IF and ID.
//               Presents the oldest one or two entries as an ordered pair.
//               Optional stall counters enabled by defining INST_FIFO_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     if_readygo,
    output logic                     fifo_allowin,
    input  logic [1:0]               if_valid_mask,
    input  logic [31:0]              if_pc0,
    input  logic [31:0]              if_pc1,
    input  logic [31:0]              if_inst0,
    input  logic [31:0]              if_inst1,
    input  logic [6:0]               if_excp,
    input  logic [1:0]               if_pred_taken,
    input  logic [31:0]              if_pred_target,
    output logic                     fifo_readygo,
    input  logic                     id_allowin,
    output logic [31:0]              fifo_pc0,
    output logic [31:0]              fifo_pc1,
    output logic [31:0]              fifo_inst0,
    output logic [31:0]              fifo_inst1,
    output logic [6:0]               fifo_excp0,
    output logic [6:0]               fifo_excp1,
    output logic [1:0]               fifo_pred_taken,
    output logic [31:0]              fifo_pred_target0,
    output logic [31:0]              fifo_pred_target1,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [31:0]              perf_full_cnt,
    output logic [31:0]              perf_empty_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_TWO     = CW'(2);
    localparam logic [CW-1:0] ALLOWIN_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    push_num;
    logic [1:0]    pop_num;
    logic          two_valid;

    ife_t          wr_slot0, wr_slot1;
    ife_t          rd_slot0, rd_slot1;
    ife_t          out_slot0, out_slot1;

    // Handshakes depend only on registered occupancy
    assign fifo_allowin = (count_q <= ALLOWIN_MAX);
    assign fifo_readygo = (count_q != '0);
    assign two_valid    = (count_q >= CNT_TWO);
    assign fifo_count   = count_q;

    // Number of entries accepted from IF this cycle; illegal masks push nothing
    always_comb begin
        push_num = 2'd0;
        if (if_readygo && fifo_allowin) begin
            case (if_valid_mask)
                MASK_ONE: push_num = 2'd1;
                MASK_TWO: push_num = 2'd2;
                default:  push_num = 2'd0;
            endcase
        end
    end

    // Number of entries consumed by ID: the whole presented pair, at most two
    always_comb begin
        pop_num = 2'd0;
        if (fifo_readygo && id_allowin) begin
            pop_num = two_valid ? 2'd2 : 2'd1;
        end
    end

    // Pointer and occupancy update; flush overrides any push or pop
    always_comb begin
        head_d  = head_q + AW'(pop_num);
        tail_d  = tail_q + AW'(push_num);
        count_d = count_q + CW'(push_num) - CW'(pop_num);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Build the entries written for the incoming slots; target is shared by the packet
    always_comb begin
        wr_slot0.target     = if_pred_target;
        wr_slot0.pred_taken = if_pred_taken[0];
        wr_slot0.excp       = if_excp;
        wr_slot0.inst       = if_inst0;
        wr_slot0.pc         = if_pc0;
        wr_slot1.target     = if_pred_target;
        wr_slot1.pred_taken = if_pred_taken[1];
        wr_slot1.excp       = if_excp;
        wr_slot1.inst       = if_inst1;
        wr_slot1.pc         = if_pc1;
    end

    inst_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we0    ((push_num != 2'd0) && !flush),
        .waddr0 (tail_q),
        .wdata0 (wr_slot0),
        .we1    ((push_num == 2'd2) && !flush),
        .waddr1 (tail_q + AW'(1)),
        .wdata1 (wr_slot1),
        .raddr0 (head_q),
        .rdata0 (rd_slot0),
        .raddr1 (head_q + AW'(1)),
        .rdata1 (rd_slot1)
    );

    // Mask stale storage with bubbles when the slot has no valid entry
    always_comb begin
        out_slot0 = fifo_readygo ? rd_slot0 : ife_bubble();
        out_slot1 = two_valid    ? rd_slot1 : ife_bubble();
    end

    assign fifo_pc0          = out_slot0.pc;
    assign fifo_pc1          = out_slot1.pc;
    assign fifo_inst0        = out_slot0.inst;
    assign fifo_inst1        = out_slot1.inst;
    assign fifo_excp0        = out_slot0.excp;
    assign fifo_excp1        = out_slot1.excp;
    assign fifo_pred_taken   = {out_slot1.pred_taken, out_slot0.pred_taken};
    assign fifo_pred_target0 = out_slot0.target;
    assign fifo_pred_target1 = out_slot1.target;

`ifdef INST_FIFO_PERF_EN
    logic [31:0] perf_full_q, perf_full_d;
    logic [31:0] perf_empty_q, perf_empty_d;

    // Count IF-blocked and ID-starved cycles; free-running, wrap naturally, survive flush
    always_comb begin
        perf_full_d  = perf_full_q  + {31'd0, (if_readygo && !fifo_allowin)};
        perf_empty_d = perf_empty_q + {31'd0, (id_allowin && !fifo_readygo)};
    end

    // Stall counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_full_q  <= 32'd0;
            perf_empty_q <= 32'd0;
        end else begin
            perf_full_q  <= perf_full_d;
            perf_empty_q <= perf_empty_d;
        end
    end

    assign perf_full_cnt  = perf_full_q;
    assign perf_empty_cnt = perf_empty_q;
`else
    assign perf_full_cnt  = 32'd0;
    assign perf_empty_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
